// File: rtl/oh_rrarb3_if.sv
// oh_rrarb3_if: request/lock inputs and registered grant outputs of the 3-way round-robin arbiter
interface oh_rrarb3_if;
    logic       en;
    logic [2:0] req;
    logic       lock;
    logic [2:0] grant;
    logic [1:0] grant_id;
    logic       valid;
    modport master (output en, req, lock, input grant, grant_id, valid);
    modport slave  (input en, req, lock, output grant, grant_id, valid);
endinterface

// File: rtl/oh_rrarb3.sv
// oh_rrarb3: 3-requester round-robin arbiter with lockable, bounded-hold one-hot grant
module oh_rrarb3 #(
    parameter string PROP    = "DEFAULT",
    parameter int    HOLDMAX = 4
) (
    input logic        clk,
    input logic        reset,
    oh_rrarb3_if.slave arb
);
    if (HOLDMAX < 1 || HOLDMAX > 255) begin : g_bad_holdmax
        $error("oh_rrarb3 %s: HOLDMAX out of range 1..255", PROP);
    end
    logic [2:0] r_grant, w_grant;
    logic [1:0] r_id, w_id, r_ptr, w_ptr;
    logic [1:0] w_c0, w_c1, w_c2, w_idx;
    logic [7:0] r_holdcnt, w_holdcnt;
    logic       r_valid, w_hold, w_any;
    // search order ptr, ptr+1, ptr+2 (mod 3)
    always_comb begin
        w_c0      = r_ptr;
        w_c1      = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
        w_c2      = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
        w_any     = |arb.req;
        w_idx     = arb.req[w_c0] ? w_c0 : arb.req[w_c1] ? w_c1 : w_c2;
        w_hold    = arb.lock && |(r_grant & arb.req) && (r_holdcnt < 8'(HOLDMAX - 1));
        w_grant   = w_hold ? r_grant : w_any ? 3'b001 << w_idx : 3'b000;
        w_id      = w_hold ? r_id : w_any ? w_idx : 2'd0;
        w_ptr     = (w_hold || !w_any) ? r_ptr : (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
        w_holdcnt = w_hold ? r_holdcnt + 8'd1 : 8'd0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant   <= 3'b000;
            r_id      <= 2'd0;
            r_valid   <= 1'b0;
            r_ptr     <= 2'd0;
            r_holdcnt <= 8'd0;
        end else if (arb.en) begin
            r_grant   <= w_grant;
            r_id      <= w_id;
            r_valid   <= |w_grant;
            r_ptr     <= w_ptr;
            r_holdcnt <= w_holdcnt;
        end
    end
    assign arb.grant    = r_grant;
    assign arb.grant_id = r_id;
    assign arb.valid    = r_valid;
endmodule

// File: tb/tb_oh_rrarb3.sv
// tb_oh_rrarb3: table-driven check of HOLDMAX=4 and HOLDMAX=1 arbiters plus async-reset sequence
module tb_oh_rrarb3;
    typedef struct {
        logic       rst;
        logic       en;
        logic       lock;
        logic [2:0] req;
        logic [2:0] g4;
        logic [2:0] g1;
    } vec_t;
    logic clk, reset;
    int checks = 0, errors = 0;
    vec_t v[$];
    oh_rrarb3_if u_if4 ();
    oh_rrarb3_if u_if1 ();
    oh_rrarb3 #(.HOLDMAX(4)) u_dut4 (.clk(clk), .reset(reset), .arb(u_if4));
    oh_rrarb3 #(.HOLDMAX(1)) u_dut1 (.clk(clk), .reset(reset), .arb(u_if1));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic add(input logic rst, en, lock, input logic [2:0] req, g4, g1);
        vec_t t;
        t.rst = rst; t.en = en; t.lock = lock; t.req = req; t.g4 = g4; t.g1 = g1;
        v.push_back(t);
    endtask
    task automatic chk(input string nm, input int idx, input logic [2:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b exp %b", nm, idx, act, exp);
        end
    endtask
    function automatic logic [2:0] id_of(input logic [2:0] g);
        return g[2] ? 3'd2 : g[1] ? 3'd1 : 3'd0;
    endfunction
    task automatic chk_all(input int idx, input logic [2:0] e4, e1);
        chk("grant4", idx, u_if4.grant, e4);
        chk("id4", idx, {1'b0, u_if4.grant_id}, id_of(e4));
        chk("valid4", idx, {2'b0, u_if4.valid}, {2'b0, |e4});
        chk("grant1", idx, u_if1.grant, e1);
        chk("id1", idx, {1'b0, u_if1.grant_id}, id_of(e1));
        chk("valid1", idx, {2'b0, u_if1.valid}, {2'b0, |e1});
    endtask
    task automatic drive(input logic rst, en, lock, input logic [2:0] req);
        reset = rst;
        u_if4.en = en; u_if4.lock = lock; u_if4.req = req;
        u_if1.en = en; u_if1.lock = lock; u_if1.req = req;
    endtask
    task automatic step(input logic rst, en, lock, input logic [2:0] req);
        @(negedge clk);
        drive(rst, en, lock, req);
        @(posedge clk);
        #1;
    endtask
    initial begin
        drive(1'b1, 1'b0, 1'b0, 3'b000);
        add(1, 0, 0, 3'b000, 3'b000, 3'b000);
        // plain round robin
        for (int i = 0; i < 6; i++)
            add(0, 1, 0, 3'b111, 3'b001 << (i % 3), 3'b001 << (i % 3));
        // locked pair: 4-cycle holds vs. no hold at HOLDMAX=1
        for (int i = 0; i < 9; i++)
            add(0, 1, 1, 3'b011, (i < 4 || i == 8) ? 3'b001 : 3'b010, (i % 2 == 0) ? 3'b001 : 3'b010);
        for (int i = 0; i < 10; i++)
            add(0, 1, 1, 3'b001, 3'b001, 3'b001);
        // locked owner 1 drops its request
        add(0, 1, 1, 3'b010, 3'b010, 3'b010);
        add(0, 1, 1, 3'b010, 3'b010, 3'b010);
        add(0, 1, 1, 3'b101, 3'b100, 3'b100);
        add(0, 1, 0, 3'b101, 3'b001, 3'b001);
        // freeze with en=0 keeps ptr and holdcnt
        add(0, 1, 1, 3'b010, 3'b010, 3'b010);
        add(0, 1, 1, 3'b010, 3'b010, 3'b010);
        add(0, 0, 0, 3'b101, 3'b010, 3'b010);
        add(0, 0, 1, 3'b000, 3'b010, 3'b010);
        add(0, 0, 0, 3'b111, 3'b010, 3'b010);
        add(0, 1, 1, 3'b011, 3'b010, 3'b001);
        add(0, 1, 1, 3'b011, 3'b010, 3'b010);
        add(0, 1, 1, 3'b011, 3'b001, 3'b001);
        add(0, 1, 0, 3'b111, 3'b010, 3'b010);
        // empty request leaves ptr alone
        add(0, 1, 0, 3'b000, 3'b000, 3'b000);
        add(0, 1, 0, 3'b111, 3'b100, 3'b100);
        add(0, 1, 0, 3'b111, 3'b001, 3'b001);
        add(0, 1, 0, 3'b111, 3'b010, 3'b010);
        // reset with ptr=2 must restart search at 0
        add(1, 1, 0, 3'b111, 3'b000, 3'b000);
        add(0, 1, 0, 3'b111, 3'b001, 3'b001);
        foreach (v[i]) begin
            step(v[i].rst, v[i].en, v[i].lock, v[i].req);
            chk_all(i, v[i].g4, v[i].g1);
        end
        step(0, 1, 0, 3'b111);
        chk_all(100, 3'b010, 3'b010);
        step(0, 1, 0, 3'b111);
        chk_all(101, 3'b100, 3'b100);
        // no combinational path from req to grant
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'b000);
        #1;
        chk_all(102, 3'b100, 3'b100);
        // asynchronous reset between edges
        reset = 1'b1;
        #1;
        chk_all(103, 3'b000, 3'b000);
        @(posedge clk);
        #1;
        chk_all(104, 3'b000, 3'b000);
        step(0, 1, 0, 3'b111);
        chk_all(105, 3'b001, 3'b001);
        step(0, 1, 0, 3'b111);
        chk_all(106, 3'b010, 3'b010);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/oh_rrarb3.md
OH_RRARB3 -- requirements
Module: oh_rrarb3

Interface
REQ-001 Parameter PROP, default "DEFAULT": implementation property tag; SHALL NOT alter function.
REQ-002 Parameter HOLDMAX, default 4: maximum consecutive cycles one locked grant is held; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  arbitration enable; 0 freezes all state.
REQ-006 req  input  3  request vector; bit i means requester i wants the shared leg.
REQ-007 lock  input  1  holds the current grant across cycles while the owner keeps requesting.
REQ-008 grant  output  3  registered one-hot grant; drives the a1/b1/c1 select legs of the downstream 3-way and-or mux.
REQ-009 grant_id  output  2  binary index of the granted requester; 0 when no grant.
REQ-010 valid  output  1  1 when grant is nonzero.

Function
REQ-011 grant SHALL always be one-hot or zero; no two bits set in any cycle.
REQ-012 Latency: a request sampled at edge N SHALL produce its grant at the output after edge N (1 cycle); grant is a pure flop output with no combinational path from req.
REQ-013 State: ptr (0..2, search start index), grant register, holdcnt (8 bits).
REQ-014 Hold rule: with en=1, if grant bit g is set, lock=1, req[g]=1 and holdcnt < HOLDMAX-1, then grant SHALL stay g and holdcnt SHALL increment.
REQ-015 Arbitration rule: with en=1 and the hold rule not met, grant SHALL become the first i with req[i]=1, searched in order ptr, ptr+1, ptr+2 (mod 3); if req=0, grant SHALL become 0.
REQ-016 On every arbitration that selects index i: ptr SHALL become (i+1) mod 3 and holdcnt SHALL become 0, including when i equals the previous owner.
REQ-017 With lock=0, each arbitration lasts 1 cycle; continuous requests from k requesters SHALL rotate grants in strict round-robin order, period k cycles.
REQ-018 Forced release: when holdcnt reaches HOLDMAX-1 under lock, the next edge SHALL re-arbitrate. Another requester wins if one is present. If the owner is the sole requester, it SHALL be re-granted with holdcnt=0.
REQ-019 HOLDMAX=1: lock SHALL have no effect.
REQ-020 Owner drops req while locked: the next edge SHALL re-arbitrate; grant SHALL never be held on a deasserted request.
REQ-021 Arbitration with req=0: ptr SHALL be unchanged.
REQ-022 en=0: grant, ptr and holdcnt SHALL hold their values regardless of req and lock.
REQ-023 grant_id and valid SHALL be registered alongside grant and always consistent with it.

Reset
REQ-024 reset=1 SHALL immediately, without a clock, force grant=000, grant_id=0, valid=0, ptr=0 and holdcnt=0.
REQ-025 Reset mid-grant SHALL discard the lock and ptr history. The first arbitration after release SHALL start its search at index 0.
REQ-026 Deassertion of reset SHALL be followed by normal operation on the next rising edge with en=1.

Verification
REQ-027 Reset, then req=111, lock=0, en=1 for 6 cycles -> grant sequence 001,010,100,001,010,100; grant_id 0,1,2,0,1,2; valid=1 throughout.
REQ-028 HOLDMAX=4, req=011, lock=1 -> grant=001 for 4 cycles, then 010 for 4 cycles, then 001 again; holdcnt 0..3 on each.
REQ-029 req=001 only, lock=1, HOLDMAX=4 for 10 cycles -> grant=001 continuously, holdcnt wraps 0,1,2,3,0,...; valid never drops.
REQ-030 Owner 1 locked, then req[1] drops at cycle 2 with req=101 -> next grant=100 (ptr=2), then 001; no cycle with two bits set.
REQ-031 Grant 010 active, en=0 for 3 cycles with req toggling -> grant stays 010; en=1 resumes from the same ptr and holdcnt.
REQ-032 Reset asserted between edges while grant=100 -> outputs are 000/0/0 before the next edge; after release with req=111, first grant=001.
